// File: rtl/instruction_fifo_writer_pkg.sv
// Shared opcode codes, instruction field positions and FSM state type for the instruction FIFO writer.
// State FILL_NEXT only exists when WRITER_FILL_EN is defined.
package instruction_fifo_writer_pkg;

  localparam logic [3:0] OP_WBR  = 4'b0000;
  localparam logic [3:0] OP_WSM  = 4'b0001;
  localparam logic [3:0] OP_FILL = 4'b1111;

  localparam int OPCODE_LSB = 0;
  localparam int REG_LSB    = 4;
  localparam int ADDR_LSB   = 4;
  localparam int COLOR_LSB  = 0;

`ifdef WRITER_FILL_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_WRITE,
    ST_FILL_NEXT
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_WRITE
  } state_t;
`endif

endpackage

// File: rtl/instruction_fifo_writer_if.sv
// Command handshake and FIFO write port of the instruction FIFO writer.
// master = host/FIFO side, slave = the writer itself.
interface instruction_fifo_writer_if #(
  parameter int ADDR_BITS = 14,
  parameter int REG_BITS  = 5
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_opcode;
  logic [REG_BITS-1:0]  cmd_reg;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [31:0]          cmd_data;
  logic [ADDR_BITS-1:0] cmd_len;
  logic                 wrfull;
  logic                 wrreq;
  logic [31:0]          dataA;
  logic [31:0]          dataB;

  modport master (
    output cmd_valid, cmd_opcode, cmd_reg, cmd_addr, cmd_data, cmd_len, wrfull,
    input  cmd_ready, wrreq, dataA, dataB
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_reg, cmd_addr, cmd_data, cmd_len, wrfull,
    output cmd_ready, wrreq, dataA, dataB
  );
endinterface

// File: rtl/instruction_fifo_writer_encoder.sv
// Combinational packer: opcode and command fields -> dataA/dataB instruction words.
// With WRITER_FILL_EN the FILL opcode is accepted and encoded as a WSM write.
import instruction_fifo_writer_pkg::*;

module instr_encoder #(
  parameter int ADDR_BITS  = 14,
  parameter int REG_BITS   = 5,
  parameter int COLOR_BITS = 9
) (
  input  logic [3:0]           opcode,
  input  logic [REG_BITS-1:0]  reg_idx,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          data,
  output logic [31:0]          word_a,
  output logic [31:0]          word_b,
  output logic                 valid,
  output logic                 fill
);

  always_comb begin
    word_a = '0;
    word_b = '0;
    valid  = 1'b0;
    fill   = 1'b0;
    case (opcode)
      OP_WBR: begin
        word_a[REG_LSB +: REG_BITS] = reg_idx;
        word_a[OPCODE_LSB +: 4]     = OP_WBR;
        word_b                      = data;
        valid                       = 1'b1;
      end
      OP_WSM: begin
        word_a[ADDR_LSB +: ADDR_BITS]    = addr;
        word_a[OPCODE_LSB +: 4]          = OP_WSM;
        word_b[COLOR_LSB +: COLOR_BITS]  = data[COLOR_BITS-1:0];
        valid                            = 1'b1;
      end
`ifdef WRITER_FILL_EN
      // A fill is a run of ordinary sprite-memory writes, so it carries the WSM opcode.
      OP_FILL: begin
        word_a[ADDR_LSB +: ADDR_BITS]    = addr;
        word_a[OPCODE_LSB +: 4]          = OP_WSM;
        word_b[COLOR_LSB +: COLOR_BITS]  = data[COLOR_BITS-1:0];
        valid                            = 1'b1;
        fill                             = 1'b1;
      end
`endif
      default: begin
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_fifo_writer.sv
// Host-side producer for the instruction FIFO: one command per handshake, one FIFO write per command.
// Optional macro WRITER_FILL_EN adds the FILL burst opcode.
import instruction_fifo_writer_pkg::*;

module instruction_fifo_writer #(
  parameter int ADDR_BITS  = 14,
  parameter int REG_BITS   = 5,
  parameter int COLOR_BITS = 9,
  parameter int COUNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_fifo_writer_if.slave bus,
  output logic                 busy,
  output logic                 err_opcode,
  output logic [COUNT_W-1:0]   issued_count
);

  state_t               state;
  logic                 cmd_ready_q;
  logic                 wrreq_q;
  logic [31:0]          data_a_q;
  logic [31:0]          data_b_q;

  logic [3:0]           enc_opcode;
  logic [ADDR_BITS-1:0] enc_addr;
  logic [31:0]          enc_data;
  logic [31:0]          enc_a;
  logic [31:0]          enc_b;
  logic                 enc_valid;
  logic                 enc_fill;

`ifdef WRITER_FILL_EN
  logic [ADDR_BITS-1:0]  fill_addr;
  logic [ADDR_BITS-1:0]  remaining;
  logic [COLOR_BITS-1:0] fill_color;
  logic                  fill_mode;
  logic [ADDR_BITS-1:0]  next_addr;

  assign next_addr = fill_addr + ADDR_BITS'(1);

  // During a burst the encoder is fed from the latched fill state instead of the live command.
  always_comb begin
    enc_opcode = bus.cmd_opcode;
    enc_addr   = bus.cmd_addr;
    enc_data   = bus.cmd_data;
    if (state == ST_FILL_NEXT) begin
      enc_opcode = OP_WSM;
      enc_addr   = next_addr;
      enc_data   = 32'(fill_color);
    end
  end
`else
  logic unused_fill_inputs;

  assign enc_opcode         = bus.cmd_opcode;
  assign enc_addr           = bus.cmd_addr;
  assign enc_data           = bus.cmd_data;
  assign unused_fill_inputs = ^{bus.cmd_len, enc_fill};
`endif

  instr_encoder #(
    .ADDR_BITS  (ADDR_BITS),
    .REG_BITS   (REG_BITS),
    .COLOR_BITS (COLOR_BITS)
  ) u_encoder (
    .opcode  (enc_opcode),
    .reg_idx (bus.cmd_reg),
    .addr    (enc_addr),
    .data    (enc_data),
    .word_a  (enc_a),
    .word_b  (enc_b),
    .valid   (enc_valid),
    .fill    (enc_fill)
  );

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wrreq     = wrreq_q;
  assign bus.dataA     = data_a_q;
  assign bus.dataB     = data_b_q;

  // Words are loaded only in IDLE/FILL_NEXT, so they are frozen across WAIT_SPACE and WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      wrreq_q      <= 1'b0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      busy         <= 1'b0;
      err_opcode   <= 1'b0;
      issued_count <= '0;
`ifdef WRITER_FILL_EN
      fill_addr    <= '0;
      remaining    <= '0;
      fill_color   <= '0;
      fill_mode    <= 1'b0;
`endif
    end else begin
      wrreq_q    <= 1'b0;
      err_opcode <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            if (!enc_valid) begin
              err_opcode <= 1'b1;
            end
`ifdef WRITER_FILL_EN
            else if (enc_fill && (bus.cmd_len == '0)) begin
              state <= ST_IDLE;
            end
`endif
            else begin
              data_a_q    <= enc_a;
              data_b_q    <= enc_b;
              state       <= ST_WAIT_SPACE;
              busy        <= 1'b1;
              cmd_ready_q <= 1'b0;
`ifdef WRITER_FILL_EN
              fill_mode   <= enc_fill;
              fill_addr   <= bus.cmd_addr;
              fill_color  <= bus.cmd_data[COLOR_BITS-1:0];
              remaining   <= bus.cmd_len - ADDR_BITS'(1);
`endif
            end
          end
        end
        ST_WAIT_SPACE: begin
          if (!bus.wrfull) begin
            state        <= ST_WRITE;
            wrreq_q      <= 1'b1;
            issued_count <= issued_count + COUNT_W'(1);
          end
        end
        ST_WRITE: begin
`ifdef WRITER_FILL_EN
          if (fill_mode && (remaining != '0)) begin
            state <= ST_FILL_NEXT;
          end else
`endif
          begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
`ifdef WRITER_FILL_EN
        ST_FILL_NEXT: begin
          fill_addr <= next_addr;
          remaining <= remaining - ADDR_BITS'(1);
          data_a_q  <= enc_a;
          data_b_q  <= enc_b;
          state     <= ST_WAIT_SPACE;
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
